// File: rtl/picomem_arbiter_2_1.sv
// picomem_arbiter_2_1
// Two-master, one-slave arbiter for the PicoMem valid/ready bus. It lets a
// second master (DMA / LCD refill engine) share one slave port with the CPU.
// Grants are round-robin and are held for the whole transaction. A watchdog
// forces completion if the slave stays silent for too long.
//
// Handshake: a master raises mX_valid with stable addr/wdata/wstrb and keeps
// it high until it sees a one-cycle mX_ready pulse. mX_ready is asserted in
// the same cycle as the slave's s_ready. A watchdog timeout also produces
// this pulse, with rdata = ERR_RDATA. Dropping mX_valid before ready aborts
// the transaction without a ready pulse.
//
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   m0_* / m1_*            master 0 (CPU) / master 1 (DMA): valid, ready,
//                          addr, wdata, wstrb (0 = read), rdata
//   s_*                    slave side: valid, ready, addr, wdata, wstrb, rdata
//   timeout_flag           sticky: a watchdog timeout has occurred
//   timeout_clr            clears timeout_flag (a new timeout wins)
//   dbg_state              current arbiter state (0 IDLE, 1 BUSY0, 2 BUSY1)
module picomem_arbiter_2_1 #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF,
  parameter int unsigned CNT_W          = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  input  logic        s_ready,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic [31:0] s_rdata,
  output logic        timeout_flag,
  input  logic        timeout_clr,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_t;

  localparam bit WD_EN = (TIMEOUT_CYCLES != 0);
  // Last counter value before the forced exit; unused when the watchdog is off.
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(TIMEOUT_CYCLES == 0 ? 0 : TIMEOUT_CYCLES - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_last_grant;
  logic [CNT_W-1:0] r_cnt;
  logic             r_timeout_flag;

  logic        w_busy;
  logic        w_sel1;
  logic        w_mx_valid;
  logic        w_timeout;
  logic        w_done;
  logic        w_abort;
  logic [31:0] w_rdata;

  assign w_busy     = (r_state == BUSY0) || (r_state == BUSY1);
  assign w_sel1     = (r_state == BUSY1);
  assign w_mx_valid = w_sel1 ? m1_valid : m0_valid;

  // Timeout fires only while the granted master is still waiting; a real
  // s_ready in the same cycle takes precedence.
  assign w_timeout = WD_EN && w_busy && w_mx_valid && !s_ready && (r_cnt == CNT_LAST);
  assign w_done    = w_busy && w_mx_valid && (s_ready || w_timeout);
  // Master withdrew its request before completion: drop back without a ready.
  assign w_abort   = w_busy && !w_mx_valid;
  assign w_rdata   = w_timeout ? ERR_RDATA : s_rdata;

  // Bus mux. Everything is zero outside BUSY, so a late s_ready from a slave
  // that already timed out never reaches a master.
  always_comb begin
    s_valid  = 1'b0;
    s_addr   = '0;
    s_wdata  = '0;
    s_wstrb  = '0;
    m0_ready = 1'b0;
    m1_ready = 1'b0;
    m0_rdata = '0;
    m1_rdata = '0;
    if (w_busy) begin
      s_valid = w_mx_valid;
      s_addr  = w_sel1 ? m1_addr  : m0_addr;
      s_wdata = w_sel1 ? m1_wdata : m0_wdata;
      s_wstrb = w_sel1 ? m1_wstrb : m0_wstrb;
      if (w_sel1) begin
        m1_ready = w_done;
        m1_rdata = w_rdata;
      end else begin
        m0_ready = w_done;
        m0_rdata = w_rdata;
      end
    end
  end

  // Next state. On a tie the master that did not win last time is granted;
  // last_grant resets to 1 so m0 wins the first tie.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (m0_valid && m1_valid) begin
          w_state_nxt = r_last_grant ? BUSY0 : BUSY1;
        end else if (m0_valid) begin
          w_state_nxt = BUSY0;
        end else if (m1_valid) begin
          w_state_nxt = BUSY1;
        end
      end
      BUSY0, BUSY1: begin
        if (w_done || w_abort) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= IDLE;
      r_last_grant   <= 1'b1;
      r_cnt          <= '0;
      r_timeout_flag <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == IDLE) && (w_state_nxt != IDLE)) begin
        r_last_grant <= (w_state_nxt == BUSY1);
      end
      // Counts waiting BUSY cycles; cleared on every exit so each grant starts
      // from zero. The forced exit at CNT_LAST keeps it from wrapping.
      if (WD_EN && w_busy && !w_done && !w_abort) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_cnt <= '0;
      end
      if (w_timeout) begin
        r_timeout_flag <= 1'b1;
      end else if (timeout_clr) begin
        r_timeout_flag <= 1'b0;
      end
    end
  end

  assign timeout_flag = r_timeout_flag;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_picomem_arbiter_2_1.sv
module tb_picomem_arbiter_2_1;

  localparam int unsigned T   = 8;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;
  localparam logic [31:0] A0  = 32'h4000_0010;
  localparam logic [31:0] D0  = 32'h0000_0000;
  localparam logic [3:0]  S0  = 4'b0000;
  localparam logic [31:0] A1  = 32'h4000_0100;
  localparam logic [31:0] D1  = 32'hA5A5_A5A5;
  localparam logic [3:0]  S1  = 4'b0011;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        m0_valid = 1'b0, m0_ready;
  logic [31:0] m0_addr = '0, m0_wdata = '0, m0_rdata;
  logic [3:0]  m0_wstrb = '0;
  logic        m1_valid = 1'b0, m1_ready;
  logic [31:0] m1_addr = '0, m1_wdata = '0, m1_rdata;
  logic [3:0]  m1_wstrb = '0;
  logic        s_valid, s_ready = 1'b0;
  logic [31:0] s_addr, s_wdata, s_rdata = '0;
  logic [3:0]  s_wstrb;
  logic        timeout_flag, timeout_clr = 1'b0;
  logic [1:0]  dbg_state;

  picomem_arbiter_2_1 #(
    .TIMEOUT_CYCLES(T),
    .ERR_RDATA(ERR),
    .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_rdata(s_rdata),
    .timeout_flag(timeout_flag), .timeout_clr(timeout_clr),
    .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // own: 0 = no grant, 1 = m0 granted, 2 = m1 granted (selects expected s_* fields)
  task automatic check_outs(input string tag, input logic sv, input logic r0, input logic r1,
                            input int own, input logic [31:0] rd0, input logic [31:0] rd1,
                            input logic flg);
    logic [31:0] ea, ed;
    logic [3:0]  es;
    ea = (own == 1) ? A0 : (own == 2) ? A1 : 32'h0;
    ed = (own == 1) ? D0 : (own == 2) ? D1 : 32'h0;
    es = (own == 1) ? S0 : (own == 2) ? S1 : 4'h0;
    chk({tag, "/s_valid"},  {31'b0, s_valid},  {31'b0, sv});
    chk({tag, "/m0_ready"}, {31'b0, m0_ready}, {31'b0, r0});
    chk({tag, "/m1_ready"}, {31'b0, m1_ready}, {31'b0, r1});
    chk({tag, "/s_addr"},   s_addr,  ea);
    chk({tag, "/s_wdata"},  s_wdata, ed);
    chk({tag, "/s_wstrb"},  {28'b0, s_wstrb}, {28'b0, es});
    chk({tag, "/m0_rdata"}, m0_rdata, rd0);
    chk({tag, "/m1_rdata"}, m1_rdata, rd1);
    chk({tag, "/flag"},     {31'b0, timeout_flag}, {31'b0, flg});
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v0, input logic v1, input logic sr,
                       input logic [31:0] rd, input logic clr);
    @(negedge clk);
    m0_valid    = v0;
    m1_valid    = v1;
    s_ready     = sr;
    s_rdata     = rd;
    timeout_clr = clr;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0; timeout_clr = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_outs("reset", 0, 0, 0, 0, 32'h0, 32'h0, 0);
    chk("reset/dbg_state", {30'b0, dbg_state}, 32'h0);
    reset = 1'b0;
  endtask

  // One full m0 grant of T BUSY cycles. On the last cycle either the slave
  // answers (ready_last) or the watchdog fires; clr_last pulses timeout_clr then.
  task automatic busy_m0(input string tag, input bit ready_last, input bit clr_last,
                         input logic flg);
    for (int i = 1; i <= int'(T); i++) begin
      logic last, sr, to;
      logic [31:0] rd;
      last = (i == int'(T));
      sr   = last && ready_last;
      to   = last && !ready_last;
      rd   = 32'h5000_0000 + 32'(i);
      drive(1, 0, sr, rd, last && clr_last);
      check_outs($sformatf("%s/c%0d", tag, i), 1, last, 0, 1, to ? ERR : rd, 32'h0, flg);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        v0, v1, sr;
    logic [31:0] rd;
    int          own;
    logic        e_sv, e_r0, e_r1;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic v0, input logic v1, input logic sr,
                              input logic [31:0] rd, input int own,
                              input logic sv, input logic r0, input logic r1);
    vec_t v;
    v.v0 = v0; v.v1 = v1; v.sr = sr; v.rd = rd; v.own = own;
    v.e_sv = sv; v.e_r0 = r0; v.e_r1 = r1;
    return v;
  endfunction

  // ---------------- reference model state ----------------
  int          md_owner, md_last, md_wait;
  bit          md_flag;
  logic        mv[2];
  logic [31:0] ma[2], mw[2];
  logic [3:0]  ms[2];
  bit          hold[2];

  initial begin
    // Test 1: single m0 read, slave answers on third BUSY cycle.
    vecs.push_back(mk(1,0,0,32'h0,         0, 0,0,0));
    vecs.push_back(mk(1,0,0,32'h0,         1, 1,0,0));
    vecs.push_back(mk(1,0,0,32'h0,         1, 1,0,0));
    vecs.push_back(mk(1,0,1,32'h1234_5678, 1, 1,1,0));
    vecs.push_back(mk(0,0,0,32'h0,         0, 0,0,0));
    // Test 2: both masters request continuously, grants alternate.
    vecs.push_back(mk(1,1,0,32'h0,         0, 0,0,0));
    vecs.push_back(mk(1,1,0,32'h1111_1111, 2, 1,0,0));
    vecs.push_back(mk(1,1,1,32'h2222_2222, 2, 1,0,1));
    vecs.push_back(mk(1,1,0,32'h0,         0, 0,0,0));
    vecs.push_back(mk(1,1,0,32'h3333_3333, 1, 1,0,0));
    vecs.push_back(mk(1,1,1,32'h4444_4444, 1, 1,1,0));
    vecs.push_back(mk(1,1,0,32'h0,         0, 0,0,0));
    vecs.push_back(mk(1,1,0,32'h0,         2, 1,0,0));
    vecs.push_back(mk(1,1,1,32'h5555_5555, 2, 1,0,1));
    vecs.push_back(mk(1,1,0,32'h0,         0, 0,0,0));
    vecs.push_back(mk(1,1,0,32'h0,         1, 1,0,0));
    vecs.push_back(mk(1,1,1,32'h6666_6666, 1, 1,1,0));
    // Test 3: m1 write, m0 joins mid-transaction, m0 granted next.
    vecs.push_back(mk(0,1,0,32'h0,         0, 0,0,0));
    vecs.push_back(mk(0,1,0,32'h0,         2, 1,0,0));
    vecs.push_back(mk(1,1,0,32'h0,         2, 1,0,0));
    vecs.push_back(mk(1,1,0,32'h0,         2, 1,0,0));
    vecs.push_back(mk(1,1,1,32'h7777_7777, 2, 1,0,1));
    vecs.push_back(mk(1,1,0,32'h0,         0, 0,0,0));
    vecs.push_back(mk(1,1,1,32'h8888_8888, 1, 1,1,0));
    vecs.push_back(mk(0,0,0,32'h0,         0, 0,0,0));
    // s_ready while idle is ignored
    vecs.push_back(mk(0,0,1,32'h9999_9999, 0, 0,0,0));

    m0_addr = A0; m0_wdata = D0; m0_wstrb = S0;
    m1_addr = A1; m1_wdata = D1; m1_wstrb = S1;

    do_reset();

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].v0, vecs[i].v1, vecs[i].sr, vecs[i].rd, 0);
      check_outs($sformatf("vec%0d", i), vecs[i].e_sv, vecs[i].e_r0, vecs[i].e_r1,
                 vecs[i].own,
                 (vecs[i].own == 1) ? vecs[i].rd : 32'h0,
                 (vecs[i].own == 2) ? vecs[i].rd : 32'h0, 0);
    end

    // Test 4: slave never answers; forced completion on BUSY cycle T.
    drive(1, 0, 0, 32'h0, 0);
    check_outs("t4/idle", 0, 0, 0, 0, 32'h0, 32'h0, 0);
    busy_m0("t4", 0, 0, 0);
    drive(0, 0, 0, 32'h0, 0);
    check_outs("t4/after", 0, 0, 0, 0, 32'h0, 32'h0, 1);
    drive(0, 0, 0, 32'h0, 0);
    check_outs("t4/idle2", 0, 0, 0, 0, 32'h0, 32'h0, 1);
    drive(0, 0, 1, 32'hCAFE_F00D, 0);
    check_outs("t4/late_ready", 0, 0, 0, 0, 32'h0, 32'h0, 1);

    // Test 5: clear, coincident ready/timeout, set beats clear.
    drive(0, 0, 0, 32'h0, 1);
    check_outs("t5/clr", 0, 0, 0, 0, 32'h0, 32'h0, 1);
    drive(1, 0, 0, 32'h0, 0);
    check_outs("t5/cleared", 0, 0, 0, 0, 32'h0, 32'h0, 0);
    busy_m0("t5/coincide", 1, 0, 0);
    drive(1, 0, 0, 32'h0, 0);
    check_outs("t5/no_flag", 0, 0, 0, 0, 32'h0, 32'h0, 0);
    busy_m0("t5/to_a", 0, 0, 0);
    drive(1, 0, 0, 32'h0, 0);
    check_outs("t5/flag_a", 0, 0, 0, 0, 32'h0, 32'h0, 1);
    busy_m0("t5/to_b", 0, 1, 1);
    drive(0, 0, 0, 32'h0, 0);
    check_outs("t5/set_wins", 0, 0, 0, 0, 32'h0, 32'h0, 1);

    // Test 6: asynchronous reset during BUSY1, then m0 wins first tie.
    drive(0, 1, 0, 32'h0, 0);
    check_outs("t6/idle", 0, 0, 0, 0, 32'h0, 32'h0, 1);
    drive(0, 1, 0, 32'h0, 0);
    check_outs("t6/busy1", 1, 0, 0, 2, 32'h0, 32'h0, 1);
    @(negedge clk);
    m0_valid = 1'b1;
    s_ready  = 1'b1;
    s_rdata  = 32'h1357_9BDF;
    reset    = 1'b1;
    #1;
    check_outs("t6/in_reset", 0, 0, 0, 0, 32'h0, 32'h0, 0);
    s_ready = 1'b0;
    @(negedge clk);
    #1;
    check_outs("t6/reset_held", 0, 0, 0, 0, 32'h0, 32'h0, 0);
    reset = 1'b0;
    drive(1, 1, 0, 32'h0, 0);
    check_outs("t6/m0_first", 1, 0, 0, 1, 32'h0, 32'h0, 0);
    drive(1, 1, 1, 32'hABCD_0001, 0);
    check_outs("t6/m0_done", 1, 1, 0, 1, 32'hABCD_0001, 32'h0, 0);
    // Reset while idle must also restore the tie-break toward m0.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    reset = 1'b0;
    drive(1, 1, 0, 32'h0, 0);
    check_outs("t6/m0_again", 1, 0, 0, 1, 32'h0, 32'h0, 0);
    // Master withdraws before ready: no ready pulse, back to idle.
    drive(0, 0, 1, 32'h0000_1111, 0);
    check_outs("abort", 0, 0, 0, 1, 32'h0000_1111, 32'h0, 0);
    drive(0, 0, 0, 32'h0, 0);
    check_outs("abort/idle", 0, 0, 0, 0, 32'h0, 32'h0, 0);

    // ---------------- randomized phase vs. reference model ----------------
    do_reset();
    md_owner = -1; md_last = 1; md_wait = 0; md_flag = 0;
    hold[0] = 0; hold[1] = 0;
    for (int c = 0; c < 3000; c++) begin
      logic        e_sv, to;
      logic [31:0] e_addr, e_wd;
      logic [3:0]  e_ws;
      logic        e_rdy[2];
      logic [31:0] e_rd[2];
      logic [135:0] exp_vec, act_vec;
      int k;
      @(negedge clk);
      for (int j = 0; j < 2; j++) begin
        if (!hold[j]) begin
          if ($urandom_range(0, 9) < 4) begin
            hold[j] = 1;
            ma[j] = $urandom;
            mw[j] = $urandom;
            ms[j] = 4'($urandom_range(0, 15));
          end
        end else if ($urandom_range(0, 49) == 0) begin
          hold[j] = 0;
        end
        mv[j] = hold[j];
      end
      m0_valid = mv[0]; m0_addr = ma[0]; m0_wdata = mw[0]; m0_wstrb = ms[0];
      m1_valid = mv[1]; m1_addr = ma[1]; m1_wdata = mw[1]; m1_wstrb = ms[1];
      s_ready     = ($urandom_range(0, 3) == 0);
      s_rdata     = $urandom;
      timeout_clr = ($urandom_range(0, 19) == 0);
      #1;
      e_sv = 0; to = 0; e_addr = '0; e_wd = '0; e_ws = '0;
      e_rdy[0] = 0; e_rdy[1] = 0; e_rd[0] = '0; e_rd[1] = '0;
      k = md_owner;
      if (k >= 0) begin
        to = mv[k] && !s_ready && (md_wait == int'(T) - 1);
        e_sv = mv[k]; e_addr = ma[k]; e_wd = mw[k]; e_ws = ms[k];
        e_rdy[k] = mv[k] && (s_ready || to);
        e_rd[k]  = to ? ERR : s_rdata;
      end
      exp_vec = {e_sv, e_rdy[0], e_rdy[1], md_flag, e_addr, e_wd, e_ws, e_rd[0], e_rd[1]};
      act_vec = {s_valid, m0_ready, m1_ready, timeout_flag, s_addr, s_wdata, s_wstrb,
                 m0_rdata, m1_rdata};
      n_checks++;
      if (act_vec !== exp_vec) begin
        n_errors++;
        $display("FAIL random cycle %0d: got %h expected %h", c, act_vec, exp_vec);
      end
      // advance model across the coming clock edge
      if (k < 0) begin
        if (mv[0] || mv[1]) begin
          md_owner = (mv[0] && mv[1]) ? 1 - md_last : (mv[0] ? 0 : 1);
          md_last  = md_owner;
          md_wait  = 0;
        end
      end else if (!mv[k] || s_ready || to) begin
        md_owner = -1;
        md_wait  = 0;
      end else begin
        md_wait++;
      end
      if (to) md_flag = 1;
      else if (timeout_clr) md_flag = 0;
      for (int j = 0; j < 2; j++) if (e_rdy[j]) hold[j] = 0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
